bp_mem_arbiter_2to1: RTL and testbench
======================================

# bp_mem_arbiter_2to1

Two-to-one arbiter that lets two cache engines (I$ and D$ UCE, or two LCE-side engines) share one `bp_mem` command/response port in the FE/ME cache test harnesses and small single-core configs. It arbitrates commands round-robin and locks the grant until the downstream handshake completes. It records the requester of every accepted command in an in-order ID queue and steers each memory response back to that requester. The downstream memory returns responses strictly in command order; the block relies on this.

## Interface
- `msg_width_p`, default `cce_mem_msg_width_lp`: width of a memory command/response message.
- `max_outstanding_p`, default 4: maximum number of commands accepted but not yet answered. Must be a power of two, at least 2.
- `clk_i`  in  1  clock.
- `reset_i`  in  1  asynchronous, active-high reset.
- `mem_cmd_i`  in  2×`msg_width_p`  commands from requester 0 and 1.
- `mem_cmd_v_i`  in  2  command valid per requester.
- `mem_cmd_ready_o`  out  2  command accepted this cycle (ready&valid semantics).
- `mem_resp_o`  out  `msg_width_p`  response payload, broadcast to both requesters.
- `mem_resp_v_o`  out  2  response valid, one-hot to the owning requester.
- `mem_resp_yumi_i`  in  2  requester consumes the response.
- `mem_cmd_o`  out  `msg_width_p`  command to memory.
- `mem_cmd_v_o`  out  1  command valid to memory.
- `mem_cmd_ready_i`  in  1  memory ready.
- `mem_resp_i`  in  `msg_width_p`  response from memory.
- `mem_resp_v_i`  in  1  response valid.
- `mem_resp_yumi_o`  out  1  response consumed.
- `outstanding_o`  out  `$clog2(max_outstanding_p)+1`  current ID-queue occupancy.

## Operation
- State machine with two states:
  - IDLE: the grant is computed combinationally from `mem_cmd_v_i` and the priority pointer `prio_r` (the requester named by `prio_r` wins ties).
  - LOCKED: the grant is held in `grant_r`.
- IDLE→LOCKED when `mem_cmd_v_o & ~mem_cmd_ready_i`. LOCKED→IDLE on `mem_cmd_v_o & mem_cmd_ready_i`.
- While LOCKED:
  - `mem_cmd_o` follows the locked requester only.
  - The other requester is never granted.
  - The locked requester must hold valid and payload stable; an assertion checks this.
- Command path:
  - `mem_cmd_v_o = mem_cmd_v_i[g] & ~id_full`.
  - `mem_cmd_ready_o[g] = mem_cmd_ready_i & ~id_full`, and is 0 for the non-granted requester.
- On an accepted command: push `g` into the ID queue and set `prio_r = ~g`.
- Response path, with `h` = head of the ID queue:
  - `mem_resp_o = mem_resp_i`.
  - `mem_resp_v_o[h] = mem_resp_v_i & ~id_empty`; the other bit is 0.
  - `mem_resp_yumi_o = mem_resp_yumi_i[h] & ~id_empty`.
  - Pop the ID queue on `mem_resp_yumi_o`.
- ID queue: circular buffer, `max_outstanding_p` entries × 1 bit.
  - Read and write pointers are `$clog2(max_outstanding_p)` bits and wrap naturally.
  - Occupancy is tracked by a counter.
- Boundary cases:
  - Full blocks a push even if a pop occurs in the same cycle.
  - A push and a pop in the same cycle when not full: the counter is unchanged and both pointers advance.
  - `mem_resp_v_i` while empty is an error: `mem_resp_yumi_o` stays 0 and an assertion fires.
  - Full plus LOCKED: `mem_cmd_v_o` drops to 0 while the lock is retained.
- Reset values (asynchronous):
  - State IDLE, `prio_r=0`, pointers 0, count 0.
  - Hence `mem_cmd_v_o=0`, `mem_cmd_ready_o=0`, `mem_resp_v_o=0`, `mem_resp_yumi_o=0`, `outstanding_o=0`.
- Reset mid-operation discards the ID queue. Memory must be reset together with the arbiter; stray responses after reset are not acknowledged.

## Timing
- Command path is zero-latency combinational: requester to memory in the same cycle.
- Response path is zero-latency combinational: memory to requester in the same cycle.
- No combinational path from `mem_cmd_ready_i` to `mem_cmd_v_o`.
- The grant updates one cycle after acceptance via `prio_r`.
- Back-to-back commands from alternating requesters sustain 1 command/cycle.
- A single requester with the other idle also sustains 1 command/cycle.
- `outstanding_o` is registered and reflects pushes and pops one cycle later.

## Structure
- Add `bp_mem_req_id_e` (`e_mem_req_0=0`, `e_mem_req_1=1`) to `bp_me_pkg`. No other shared types are needed.
- One sub-module: `bp_mem_arbiter_id_fifo`. It is a 1-bit-wide circular FIFO with depth `max_outstanding_p`, asynchronous reset, `full_o`/`empty_o`/`count_o`, and full-blocks-push semantics.
- The arbitration FSM and response steering live in the top module.

## Test plan
- After reset, requester 1 issues one command with memory ready → `mem_cmd_ready_o=2'b10` that cycle, `outstanding_o=1` next cycle. A response then gives `mem_resp_v_o=2'b10`, and yumi returns `outstanding_o` to 0.
- Both requesters valid continuously with memory always ready → grants alternate 0,1,0,1; each requester receives exactly 8 of 16 commands.
- Requester 0 valid with `mem_cmd_ready_i` low for 5 cycles while requester 1 raises valid at cycle 2 → grant stays on 0. Requester 0 is accepted at cycle 6 and requester 1 at cycle 7.
- With `max_outstanding_p=4`, issue 4 commands with no responses → `mem_cmd_v_o=0` and `mem_cmd_ready_o=0`. In the cycle the first response pops, a 5th command is still blocked; it is accepted the following cycle.
- Commands in order 0,0,1,0, then in-order responses with random requester yumi stalls → `mem_resp_v_o` sequence 01,01,10,01 and payloads match; the pointers wrap after 6 more commands with no misrouting.
- Assert `reset_i` asynchronously with 3 outstanding → all outputs 0 immediately and `outstanding_o=0`. After reset is released, the first command is granted to requester 0 when both are valid.

Source files
------------

// File: rtl/bp_me_pkg.sv
// rtl/bp_me_pkg.sv - shared memory-engine types for the bp_mem arbiter
package bp_me_pkg;

  localparam int cce_mem_msg_width_lp = 64;

  typedef enum logic {
    e_mem_req_0 = 1'b0,
    e_mem_req_1 = 1'b1
  } bp_mem_req_id_e;

endpackage

// File: rtl/bp_mem_arbiter_id_fifo.sv
// rtl/bp_mem_arbiter_id_fifo.sv - 1-bit circular FIFO holding the requester of each outstanding command
module bp_mem_arbiter_id_fifo #(
  parameter int depth_p = 4
) (
  input  logic                       clk_i,
  input  logic                       reset_i,
  input  logic                       push_i,
  input  logic                       data_i,
  input  logic                       pop_i,
  output logic                       data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(depth_p):0]   count_o
);

  localparam int ptr_w_lp = $clog2(depth_p);
  localparam int cnt_w_lp = ptr_w_lp + 1;

  logic [depth_p-1:0]  mem_q, mem_d;
  logic [ptr_w_lp-1:0] rptr_q, rptr_d;
  logic [ptr_w_lp-1:0] wptr_q, wptr_d;
  logic [cnt_w_lp-1:0] count_q, count_d;
  logic                push_ok, pop_ok;

  assign full_o  = (count_q == cnt_w_lp'(depth_p));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign data_o  = mem_q[rptr_q];

  // A full queue refuses the push even when a pop frees a slot this cycle.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    mem_d   = mem_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (push_ok) begin
      mem_d[wptr_q] = data_i;
      wptr_d        = wptr_q + ptr_w_lp'(1);
    end
    if (pop_ok) begin
      rptr_d = rptr_q + ptr_w_lp'(1);
    end
    unique case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + cnt_w_lp'(1);
      2'b01:   count_d = count_q - cnt_w_lp'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mem_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/bp_mem_arbiter_2to1.sv
// rtl/bp_mem_arbiter_2to1.sv - round-robin 2:1 bp_mem arbiter with in-order response steering
module bp_mem_arbiter_2to1
  import bp_me_pkg::*;
#(
  parameter int msg_width_p       = cce_mem_msg_width_lp,
  parameter int max_outstanding_p = 4
) (
  input  logic                                 clk_i,
  input  logic                                 reset_i,
  input  logic [2*msg_width_p-1:0]             mem_cmd_i,
  input  logic [1:0]                           mem_cmd_v_i,
  output logic [1:0]                           mem_cmd_ready_o,
  output logic [msg_width_p-1:0]               mem_resp_o,
  output logic [1:0]                           mem_resp_v_o,
  input  logic [1:0]                           mem_resp_yumi_i,
  output logic [msg_width_p-1:0]               mem_cmd_o,
  output logic                                 mem_cmd_v_o,
  input  logic                                 mem_cmd_ready_i,
  input  logic [msg_width_p-1:0]               mem_resp_i,
  input  logic                                 mem_resp_v_i,
  output logic                                 mem_resp_yumi_o,
  output logic [$clog2(max_outstanding_p):0]   outstanding_o
);

  typedef enum logic {
    e_arb_idle   = 1'b0,
    e_arb_locked = 1'b1
  } arb_state_e;

  arb_state_e      state_q, state_d;
  bp_mem_req_id_e  prio_q, prio_d;
  bp_mem_req_id_e  grant_q, grant_d;
  bp_mem_req_id_e  grant;
  logic [msg_width_p-1:0] cmd_sel;
  logic            cmd_accept;
  logic            id_full, id_empty, id_head;

  // A stalled command keeps its grant so the payload seen by memory never switches mid-handshake.
  always_comb begin
    if (state_q == e_arb_locked) begin
      grant = grant_q;
    end else if (&mem_cmd_v_i) begin
      grant = prio_q;
    end else if (mem_cmd_v_i[1]) begin
      grant = e_mem_req_1;
    end else begin
      grant = e_mem_req_0;
    end
  end

  assign cmd_sel     = (grant == e_mem_req_1) ? mem_cmd_i[2*msg_width_p-1:msg_width_p]
                                              : mem_cmd_i[msg_width_p-1:0];
  assign mem_cmd_o   = cmd_sel;
  assign mem_cmd_v_o = mem_cmd_v_i[grant] & ~id_full;
  assign cmd_accept  = mem_cmd_v_o & mem_cmd_ready_i;

  always_comb begin
    mem_cmd_ready_o        = '0;
    mem_cmd_ready_o[grant] = cmd_accept;
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    prio_d  = prio_q;
    unique case (state_q)
      e_arb_idle: begin
        if (mem_cmd_v_o & ~mem_cmd_ready_i) begin
          state_d = e_arb_locked;
          grant_d = grant;
        end
      end
      e_arb_locked: begin
        if (cmd_accept) begin
          state_d = e_arb_idle;
        end
      end
      default: state_d = e_arb_idle;
    endcase
    if (cmd_accept) begin
      prio_d = bp_mem_req_id_e'(~grant);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= e_arb_idle;
      grant_q <= e_mem_req_0;
      prio_q  <= e_mem_req_0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      prio_q  <= prio_d;
    end
  end

  bp_mem_arbiter_id_fifo #(
    .depth_p (max_outstanding_p)
  ) id_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (cmd_accept),
    .data_i  (grant == e_mem_req_1),
    .pop_i   (mem_resp_yumi_o),
    .data_o  (id_head),
    .full_o  (id_full),
    .empty_o (id_empty),
    .count_o (outstanding_o)
  );

  // Memory answers in command order, so the queue head names the owner of the current response.
  assign mem_resp_o      = mem_resp_i;
  assign mem_resp_yumi_o = mem_resp_yumi_i[id_head] & ~id_empty;

  always_comb begin
    mem_resp_v_o          = '0;
    mem_resp_v_o[id_head] = mem_resp_v_i & ~id_empty;
  end

  lock_stable_a: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == e_arb_locked) |-> (mem_cmd_v_i[grant_q] && $stable(cmd_sel)));

  resp_when_empty_a: assert property (@(posedge clk_i) disable iff (reset_i)
    mem_resp_v_i |-> !id_empty);

endmodule

// File: tb/tb_bp_mem_arbiter_2to1.sv
// tb/tb_bp_mem_arbiter_2to1.sv - randomized scoreboard bench for bp_mem_arbiter_2to1
module tb_bp_mem_arbiter_2to1;

  localparam int W = 16;
  localparam int N = 4;
  localparam int CW = $clog2(N) + 1;
  localparam logic [W-1:0] RESP_MASK = 16'hA5C3;

  logic             clk = 1'b0;
  logic             reset_i;
  logic [2*W-1:0]   mem_cmd_i;
  logic [1:0]       mem_cmd_v_i;
  logic [1:0]       mem_cmd_ready_o;
  logic [W-1:0]     mem_resp_o;
  logic [1:0]       mem_resp_v_o;
  logic [1:0]       mem_resp_yumi_i;
  logic [W-1:0]     mem_cmd_o;
  logic             mem_cmd_v_o;
  logic             mem_cmd_ready_i;
  logic [W-1:0]     mem_resp_i;
  logic             mem_resp_v_i;
  logic             mem_resp_yumi_o;
  logic [CW-1:0]    outstanding_o;

  always #5 clk = ~clk;

  bp_mem_arbiter_2to1 #(.msg_width_p(W), .max_outstanding_p(N)) dut (
    .clk_i           (clk),
    .reset_i         (reset_i),
    .mem_cmd_i       (mem_cmd_i),
    .mem_cmd_v_i     (mem_cmd_v_i),
    .mem_cmd_ready_o (mem_cmd_ready_o),
    .mem_resp_o      (mem_resp_o),
    .mem_resp_v_o    (mem_resp_v_o),
    .mem_resp_yumi_i (mem_resp_yumi_i),
    .mem_cmd_o       (mem_cmd_o),
    .mem_cmd_v_o     (mem_cmd_v_o),
    .mem_cmd_ready_i (mem_cmd_ready_i),
    .mem_resp_i      (mem_resp_i),
    .mem_resp_v_i    (mem_resp_v_i),
    .mem_resp_yumi_o (mem_resp_yumi_o),
    .outstanding_o   (outstanding_o)
  );

  int checks = 0;
  int errors = 0;

  // requester side
  bit           v[2];
  logic [W-1:0] pl[2];
  int           rem[2];
  int           pv, pready, presp, pyumi;

  // reference model: priority pointer, lock owner, queue of owners
  int           m_prio;
  int           m_lock;
  int           m_id_q[$];

  // scoreboard {owner, expected response payload} and memory model
  logic [W:0]   sb_q[$];
  logic [W-1:0] mem_q[$];
  bit           resp_v;
  logic [W-1:0] resp_d;
  int           acc_log[$];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit roll(int p);
    return ($urandom_range(99) < p);
  endfunction

  task automatic drive_inputs();
    mem_cmd_v_i     = {v[1], v[0]};
    mem_cmd_i       = {pl[1], pl[0]};
    mem_cmd_ready_i = roll(pready);
    mem_resp_v_i    = resp_v;
    mem_resp_i      = resp_v ? resp_d : '0;
    mem_resp_yumi_i = resp_v ? {roll(pyumi), roll(pyumi)} : 2'b00;
  endtask

  task automatic cycle();
    int           g;
    bit           exp_v, acc, pop, cap, mem_pop;
    logic [1:0]   exp_rdy, exp_rv;
    logic [W-1:0] cap_d;
    for (int r = 0; r < 2; r++) begin
      if (!v[r] && rem[r] > 0 && roll(pv)) begin
        v[r]  = 1'b1;
        pl[r] = {r[0], 15'($urandom)};
        rem[r]--;
      end
    end
    if (!resp_v && mem_q.size() > 0 && roll(presp)) begin
      resp_v = 1'b1;
      resp_d = mem_q[0] ^ RESP_MASK;
    end
    drive_inputs();
    @(negedge clk);
    if (m_lock >= 0) g = m_lock;
    else if (v[0] && v[1]) g = m_prio;
    else if (v[1]) g = 1;
    else g = 0;
    exp_v   = v[g] && (m_id_q.size() < N);
    acc     = exp_v && mem_cmd_ready_i;
    exp_rdy = acc ? (2'b01 << g) : 2'b00;
    pop     = (m_id_q.size() > 0) && mem_resp_yumi_i[m_id_q[0]];
    exp_rv  = (resp_v && m_id_q.size() > 0) ? (2'b01 << m_id_q[0]) : 2'b00;
    chk("cmd_v", mem_cmd_v_o, exp_v);
    chk("cmd_ready", mem_cmd_ready_o, exp_rdy);
    if (exp_v) chk("cmd_data", mem_cmd_o, pl[g]);
    chk("resp_v", mem_resp_v_o, exp_rv);
    chk("resp_yumi", mem_resp_yumi_o, pop);
    chk("outstanding", outstanding_o, m_id_q.size());
    if (mem_cmd_ready_o == 2'b01) acc_log.push_back(0);
    else if (mem_cmd_ready_o == 2'b10) acc_log.push_back(1);
    cap     = mem_cmd_v_o && mem_cmd_ready_i;
    cap_d   = mem_cmd_o;
    mem_pop = mem_resp_yumi_o;
    @(posedge clk);
    #1;
    if (acc) begin
      m_id_q.push_back(g);
      sb_q.push_back({g[0], pl[g] ^ RESP_MASK});
      v[g]   = 1'b0;
      m_prio = 1 - g;
      m_lock = -1;
    end else if (exp_v) begin
      m_lock = g;
    end
    if (pop) void'(m_id_q.pop_front());
    if (cap) mem_q.push_back(cap_d);
    if (mem_pop) begin
      if (mem_q.size() > 0) void'(mem_q.pop_front());
      resp_v = 1'b0;
    end
  endtask

  task automatic drain(int budget, string name);
    int n = 0;
    while ((rem[0] + rem[1] > 0 || v[0] || v[1] || mem_q.size() > 0 || sb_q.size() > 0 ||
            m_id_q.size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_drain: still busy after %0d cycles", name, n);
    end
  endtask

  task automatic clear_all();
    v = '{0, 0};
    rem = '{0, 0};
    resp_v = 1'b0;
    mem_q.delete();
    sb_q.delete();
    m_id_q.delete();
    acc_log.delete();
    m_prio = 0;
    m_lock = -1;
    mem_cmd_v_i     = 2'b00;
    mem_cmd_ready_i = 1'b0;
    mem_resp_v_i    = 1'b0;
    mem_resp_yumi_i = 2'b00;
  endtask

  task automatic check_idle_outputs(string name);
    chk({name, "_cmd_v"}, mem_cmd_v_o, 0);
    chk({name, "_cmd_ready"}, mem_cmd_ready_o, 0);
    chk({name, "_resp_v"}, mem_resp_v_o, 0);
    chk({name, "_resp_yumi"}, mem_resp_yumi_o, 0);
    chk({name, "_outstanding"}, outstanding_o, 0);
  endtask

  always @(negedge clk) begin
    if (!reset_i) begin
      for (int r = 0; r < 2; r++) begin
        if (mem_resp_v_o[r] && mem_resp_yumi_i[r]) begin
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL resp_unexpected: got response for requester %0d, expected none", r);
          end else begin
            logic [W:0] e;
            e = sb_q.pop_front();
            chk("resp_owner", r, e[W]);
            chk("resp_data", mem_resp_o, e[W-1:0]);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    pl = '{16'h0, 16'h0};
    mem_cmd_i  = '0;
    mem_resp_i = '0;
    reset_i    = 1'b1;
    clear_all();
    repeat (3) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    @(negedge clk);
    reset_i = 1'b0;
    @(posedge clk);
    #1;

    // single command from requester 1
    pv = 100; pready = 100; presp = 100; pyumi = 100;
    rem = '{0, 1};
    drain(50, "single");
    chk("single_count", acc_log.size(), 1);
    if (acc_log.size() > 0) chk("single_owner", acc_log[0], 1);

    // both requesters continuously valid: strict alternation
    acc_log.delete();
    rem = '{8, 8};
    drain(200, "alternate");
    chk("alt_count", acc_log.size(), 16);
    for (int i = 0; i < acc_log.size(); i++) chk("alt_grant", acc_log[i], i % 2);

    // memory stalls while requester 1 joins: grant stays locked on 0
    acc_log.delete();
    pready = 0;
    rem = '{1, 0};
    repeat (2) cycle();
    rem[1] = 1;
    repeat (3) cycle();
    pready = 100;
    drain(50, "lock");
    chk("lock_count", acc_log.size(), 2);
    if (acc_log.size() == 2) begin
      chk("lock_first", acc_log[0], 0);
      chk("lock_second", acc_log[1], 1);
    end

    // fill the ID queue, then release responses
    acc_log.delete();
    presp = 0;
    rem = '{3, 2};
    repeat (6) cycle();
    chk("full_outstanding", outstanding_o, N);
    chk("full_accepted", acc_log.size(), N);
    presp = 100;
    drain(100, "full");

    // random traffic with stalls on every interface
    pv = 60; pready = 70; presp = 50; pyumi = 60;
    rem = '{40, 40};
    drain(3000, "random");

    // asynchronous reset with outstanding commands
    pv = 100; pready = 100; presp = 0;
    rem = '{5, 5};
    for (int i = 0; i < 20 && m_id_q.size() < 3; i++) cycle();
    chk("pre_reset_outstanding", outstanding_o, 3);
    #2;
    reset_i = 1'b1;
    clear_all();
    #1;
    check_idle_outputs("async_reset");
    @(negedge clk);
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    pv = 100; pready = 100; presp = 100; pyumi = 100;
    rem = '{1, 1};
    drain(50, "post_reset");
    if (acc_log.size() > 0) chk("post_reset_first", acc_log[0], 0);
    else chk("post_reset_count", acc_log.size(), 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
